// File: rtl/arith_step_counter.sv
// Registered up/down counter with programmable step, wrap-or-saturate overflow
// handling, parallel load, and overflow/underflow pulse plus sticky reporting.
module arith_step_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  input  logic              sat,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              ovf_pulse,
  output logic              unf_pulse,
  output logic              ovf_sticky,
  output logic              zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_pulse_q, ovf_pulse_d;
  logic             unf_pulse_q, unf_pulse_d;
  logic             ovf_sticky_q, ovf_sticky_d;
  logic [WIDTH-1:0] step_ext;
  logic [WIDTH:0]   up_res;
  logic [WIDTH:0]   dn_res;

  // Returns {overflow, next_count}; the carry out of a WIDTH+1 bit sum marks overflow.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] inc,
                                              input logic             sat_mode);
    logic [WIDTH:0] sum;
    sum = {1'b0, cur} + {1'b0, inc};
    if (sum[WIDTH] && sat_mode) begin
      return {1'b1, ALL_ONES};
    end
    return sum;
  endfunction

  // Returns {underflow, next_count}; the borrow bit is set exactly when dec > cur.
  function automatic logic [WIDTH:0] sub_step(input logic [WIDTH-1:0] cur,
                                              input logic [WIDTH-1:0] dec,
                                              input logic             sat_mode);
    logic [WIDTH:0] diff;
    diff = {1'b0, cur} - {1'b0, dec};
    if (diff[WIDTH] && sat_mode) begin
      return {1'b1, {WIDTH{1'b0}}};
    end
    return diff;
  endfunction

  assign step_ext = WIDTH'(step);
  assign up_res   = add_step(count_q, step_ext, sat);
  assign dn_res   = sub_step(count_q, step_ext, sat);

  always_comb begin
    count_d     = count_q;
    ovf_pulse_d = 1'b0;
    unf_pulse_d = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      if (dir) begin
        count_d     = up_res[WIDTH-1:0];
        ovf_pulse_d = up_res[WIDTH];
      end else begin
        count_d     = dn_res[WIDTH-1:0];
        unf_pulse_d = dn_res[WIDTH];
      end
    end
    // A new event on the same edge as a clear keeps the flag set.
    ovf_sticky_d = (ovf_sticky_q & ~clr_flags) | ovf_pulse_d | unf_pulse_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      ovf_pulse_q  <= 1'b0;
      unf_pulse_q  <= 1'b0;
      ovf_sticky_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      ovf_pulse_q  <= ovf_pulse_d;
      unf_pulse_q  <= unf_pulse_d;
      ovf_sticky_q <= ovf_sticky_d;
    end
  end

  assign count      = count_q;
  assign ovf_pulse  = ovf_pulse_q;
  assign unf_pulse  = unf_pulse_q;
  assign ovf_sticky = ovf_sticky_q;
  assign zero       = (count_q == '0);

endmodule

// File: doc/arith_step_counter.md
Name: arith_step_counter

Overview:
Registered, parametrised up/down counter with programmable step. It generalises the team's combinational 4-bit incrementor: adjustable width, up and down counting, a step size greater than one, a choice of wrap or saturate on overflow, a parallel load, and overflow/underflow reporting as both a pulse and a sticky flag. It sits in the arithmetic-operations group and serves as the sequencing and accumulation primitive for later blocks.

Parameters:
- WIDTH, 8, counter width in bits (must be at least 2).
- STEP_W, 4, width of the step input in bits (must be at least 1 and at most WIDTH).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset; asynchronous, active-high.
- en, input, 1, count enable; one step is applied per cycle while high.
- load, input, 1, parallel load strobe.
- load_val, input, WIDTH, value written to count on load.
- dir, input, 1, direction: 1 = up, 0 = down.
- step, input, STEP_W, unsigned step magnitude, zero-extended to WIDTH.
- sat, input, 1, overflow mode: 1 = saturate, 0 = wrap.
- clr_flags, input, 1, clears ovf_sticky.
- count, output, WIDTH, current counter value (registered).
- ovf_pulse, output, 1, high for one cycle after an up-count overflow (registered).
- unf_pulse, output, 1, high for one cycle after a down-count underflow (registered).
- ovf_sticky, output, 1, latched "overflow or underflow occurred" flag.
- zero, output, 1, high when count == 0 (combinational from the count register).

Behaviour:
- Reset (rst high, asynchronous, any time including mid-count):
  - count = 0, ovf_pulse = 0, unf_pulse = 0, ovf_sticky = 0, therefore zero = 1.
  - The block is held in this state while rst is high.
  - Operation resumes on the first rising edge of clk after rst is released.
- Priority on each rising edge: rst, then load, then en, then hold.
- load:
  - count takes load_val.
  - ovf_pulse and unf_pulse are 0 on that cycle.
  - ovf_sticky is unchanged.
  - en is ignored on that cycle.
- en = 1, dir = 1 (up):
  - sum = {1'b0, count} + zero-extended step, computed at WIDTH+1 bits.
  - If sum[WIDTH] = 1, this is an overflow:
    - wrap mode: count = sum[WIDTH-1:0].
    - saturate mode: count = all ones.
    - ovf_pulse = 1 for the next cycle.
  - Otherwise count = sum[WIDTH-1:0].
- en = 1, dir = 0 (down):
  - If step > count, this is an underflow:
    - wrap mode: count = (count - step) mod 2^WIDTH.
    - saturate mode: count = 0.
    - unf_pulse = 1 for the next cycle.
  - Otherwise count = count - step.
- Step of zero with en = 1: count holds and no flag is raised.
- Exact boundaries are not overflow/underflow events:
  - Up-count reaching all ones exactly raises no flag.
  - Down-count reaching 0 exactly raises no flag.
- Saturate mode when already at the limit:
  - count = max with a further up step: count stays at max and ovf_pulse = 1 again.
  - count = 0 with a further down step of 1 or more: count stays at 0 and unf_pulse = 1 again.
- Pulses:
  - Registered, so they are valid in the same cycle as the count value they describe.
  - They deassert on the next edge unless a new event occurs.
  - Back-to-back events keep the pulse high continuously.
- ovf_sticky:
  - Set on any cycle in which ovf_pulse or unf_pulse is being registered high.
  - Cleared by clr_flags.
  - If set and clear occur on the same edge, set wins.
- Latency:
  - Inputs sampled at edge N are reflected on count and the flags after edge N.
  - zero follows count combinationally and has no added latency.
- No X propagation: every register has a defined reset value, and all inputs are treated as 2-state.

Test Plan:
- Run all tests with WIDTH=4, STEP_W=4.
- Reset, then load 14; en=1, dir=1, step=1, sat=0 -> count 15 with no flag; next cycle count 0, ovf_pulse=1 for one cycle, ovf_sticky=1, zero=1.
- Load 15; sat=1, step=3, up for 2 cycles -> count stays 15; ovf_pulse high on both cycles; ovf_sticky=1.
- Load 2; dir=0, step=5, sat=0 -> count 13 and unf_pulse=1. Repeat with sat=1 from 2 -> count 0 and unf_pulse=1.
- Load 5; en=1, up, step=1 held while load=1 with load_val=9 -> count 9 (load wins). Drop load -> 10, 11, and so on.
- With ovf_sticky=1, pulse clr_flags while a new overflow occurs on the same edge -> ovf_sticky stays 1. Then clr_flags alone -> ovf_sticky=0.
- Mid-count (count=7), assert rst between clock edges -> count=0, ovf_sticky=0, and both pulses 0 immediately without waiting for a clock edge; counting resumes from 0 after rst is released.
